noc_stream_traffic_gen_chk: RTL and testbench
=============================================

// Module: noc_stream_traffic_gen_chk
// PURPOSE
//  Synthesisable, parametrised NoC stream traffic generator + checker for Aurora/NFC link bring-up.
//  TX side drives hs_o_noc_bus_* of an aurora_top, with selectable data patterns and packet framing.
//  RX side consumes hs_i_noc_bus_* from the far-end aurora_top, with a programmable backpressure
//  duty cycle to exercise NFC, and checks the payload against an identical expected-pattern generator.
//  Sits beside aurora_top in hardware and in sim, driven from a CSR block.
// PARAMETERS
//  DATA_W      32            payload width; 8..64
//  LEN_W       16            width of packet-length and packet-count fields
//  THR_W       8             throttle counter width; RX ready duty period = 2^THR_W cycles
//  CONST_PAT   32'h5A5A5A5A  mode-1 constant word, zero-extended/truncated to DATA_W
//  LFSR_SEED   32'h00000001  mode-2 initial state; must be non-zero
// PORTS
//  hs_clock        in   1       single clock for all logic
//  pcie_reset      in   1       asynchronous, active-high reset
//  cfg_enable      in   1       level; run generator/checker
//  cfg_clear       in   1       pulse; zero status, reload pattern state; ignored while busy=1
//  cfg_mode        in   2       0 incr, 1 constant, 2 LFSR, 3 = incr
//  cfg_pkt_len     in   LEN_W   beats per packet; 0 treated as 1
//  cfg_pkt_count   in   LEN_W   packets to send; 0 = unlimited
//  cfg_throttle_en in   1       1: RX ready follows duty pattern; 0: RX ready constant
//  link_up         in   1       aurora channel_up, already in hs_clock domain
//  o_valid         out  1       TX valid
//  o_ready         in   1       TX ready from aurora_top
//  o_last          out  1       TX last beat of packet
//  o_fragment      out  DATA_W  TX payload
//  i_valid         in   1       RX valid from aurora_top
//  i_ready         out  1       RX ready to aurora_top
//  i_payload       in   DATA_W  RX payload
//  busy            out  1       generator not in IDLE/DONE
//  done            out  1       finite run complete
//  tx_beats        out  32      accepted TX beats, saturating
//  rx_beats        out  32      accepted RX beats, saturating
//  err_count       out  16      RX mismatches, saturating at 16'hFFFF
//  first_err_data  out  DATA_W  payload of the first mismatch
//  first_err_exp   out  DATA_W  expected value at the first mismatch
// BEHAVIOUR
//  Reset: all outputs 0. Pattern state is loaded (incr=1, LFSR=LFSR_SEED). FSM = IDLE.
//  TX beat = o_valid&o_ready. RX beat = i_valid&i_ready.
//  Generator FSM:
//   IDLE: cfg_enable&link_up -> SEND; o_valid rises the next cycle.
//   SEND: while cfg_enable&link_up, o_valid=1 with data/last from pattern state.
//   - Once o_valid=1, it holds with o_fragment/o_last stable until a TX beat. No retraction,
//     including when link_up or cfg_enable drops.
//   - After a beat, the next beat is presented the following cycle (no bubble) only if
//     cfg_enable&link_up. Otherwise o_valid=0, waiting for link_up.
//   - o_last=1 on beat index len-1 (len = max(cfg_pkt_len,1)). Beat index wraps to 0 after last.
//   - cfg_enable low: finish the current packet through its last beat, then go to IDLE.
//   - Final packet's last beat with cfg_pkt_count!=0: go to DONE, o_valid=0.
//   DONE: done=1, busy=0. cfg_enable low -> IDLE, done cleared.
//  Pattern: state advances only on a beat.
//   - mode0: +1 mod 2^DATA_W; sequence 1,2,3...
//   - mode1: CONST_PAT.
//   - mode2: 32-bit Fibonacci LFSR, taps 32,22,2,1, shift left, feedback into bit0.
//     Word = state replicated/truncated to DATA_W.
//   - cfg_mode and cfg_pkt_len are sampled on IDLE->SEND and held for the run.
//  Checker:
//   - Independent expected generator using the same mode; advances per RX beat.
//   - Mismatch: err_count+1 (saturating). first_err_* captured only when err_count==0.
//   - i_ready = cfg_enable & (cfg_throttle_en ? ~thr_cnt[THR_W-1] : 1).
//   - thr_cnt is free-running while cfg_enable=1, reset to 0 otherwise.
//     This gives ready high for 2^(THR_W-1) cycles, then low for 2^(THR_W-1).
//  cfg_clear (idle only): tx/rx/err counts, first_err_*, done and both pattern states reset
//   to their reset values in 1 cycle.
//  Simultaneous TX and RX beats are independent; both counters update in the same cycle.
//  pcie_reset mid-packet: immediate return to reset state. No partial packet is completed.
// TESTING
//  1 mode0, len=4, count=3, o_ready=1, link_up=1
//     -> 12 beats, data 1..12, o_last on 4/8/12, done=1, tx_beats=12.
//  2 loopback TX->RX, mode2, throttle_en=1, THR_W=8
//     -> i_ready 128 high/128 low, err_count=0, rx_beats==tx_beats.
//  3 mode0 loopback, force RX beat 5 payload to 32'hDEAD
//     -> err_count=1, first_err_data=32'hDEAD, first_err_exp=5.
//  4 drop o_ready and link_up mid-beat 7
//     -> o_valid held, o_fragment=7 stable; continues with 8 after ready and link_up return.
//  5 cfg_enable low at beat 2 of len=8
//     -> beats 3..8 still sent, o_last on 8, then IDLE with o_valid=0.
//  6 assert pcie_reset during SEND
//     -> o_valid=0, counts=0 asynchronously; restart gives data=1.

Source files
------------

// File: rtl/noc_stream_traffic_gen_chk_if.sv
// noc_stream_traffic_gen_chk_if: NoC stream TX/RX handshake bundle between the traffic gen/checker and aurora_top
//   o_valid/o_ready/o_last/o_fragment : TX stream, generator -> aurora_top
//   i_valid/i_ready/i_payload         : RX stream, aurora_top -> checker
//   master = generator/checker side, slave = aurora_top side
interface noc_stream_traffic_gen_chk_if #(
    parameter int DATA_W = 32
);
    logic              o_valid;
    logic              o_ready;
    logic              o_last;
    logic [DATA_W-1:0] o_fragment;
    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_payload;

    modport master (
        output o_valid, o_last, o_fragment, i_ready,
        input  o_ready, i_valid, i_payload
    );

    modport slave (
        input  o_valid, o_last, o_fragment, i_ready,
        output o_ready, i_valid, i_payload
    );
endinterface

// File: rtl/noc_stream_traffic_gen_chk.sv
// noc_stream_traffic_gen_chk: NoC stream traffic generator + payload checker for Aurora/NFC link bring-up
//   hs_clock, pcie_reset (async, active-high)
//   cfg_enable, cfg_clear, cfg_mode, cfg_pkt_len, cfg_pkt_count, cfg_throttle_en : CSR controls
//   link_up : aurora channel_up
//   bus     : TX (o_*) and RX (i_*) stream handshakes
//   busy, done, tx_beats, rx_beats, err_count, first_err_data, first_err_exp : status
module noc_stream_traffic_gen_chk #(
    parameter int          DATA_W    = 32,
    parameter int          LEN_W     = 16,
    parameter int          THR_W     = 8,
    parameter logic [31:0] CONST_PAT = 32'h5A5A5A5A,
    parameter logic [31:0] LFSR_SEED = 32'h00000001
) (
    input  logic                hs_clock,
    input  logic                pcie_reset,
    input  logic                cfg_enable,
    input  logic                cfg_clear,
    input  logic [1:0]          cfg_mode,
    input  logic [LEN_W-1:0]    cfg_pkt_len,
    input  logic [LEN_W-1:0]    cfg_pkt_count,
    input  logic                cfg_throttle_en,
    input  logic                link_up,
    noc_stream_traffic_gen_chk_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [31:0]         tx_beats,
    output logic [31:0]         rx_beats,
    output logic [15:0]         err_count,
    output logic [DATA_W-1:0]   first_err_data,
    output logic [DATA_W-1:0]   first_err_exp
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [DATA_W-1:0] c,
                                              input logic [31:0] l);
        return m == 2'd1 ? DATA_W'(CONST_PAT) : m == 2'd2 ? DATA_W'({l, l}) : c;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    logic [1:0]        state;
    logic [1:0]        mode_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  beat_idx;
    logic [LEN_W-1:0]  pkt_cnt;
    logic              o_valid_r;
    logic [DATA_W-1:0] tx_cnt;
    logic [DATA_W-1:0] rx_cnt;
    logic [31:0]       tx_lfsr;
    logic [31:0]       rx_lfsr;
    logic [THR_W-1:0]  thr_cnt;
    logic              tx_beat;
    logic              tx_last;
    logic              final_pkt;
    logic              rx_beat;
    logic              idle_clr;
    logic              incr_m;
    logic [DATA_W-1:0] rx_exp;

    assign busy           = state == SEND;
    assign done           = state == DONE;
    assign idle_clr       = cfg_clear & ~busy;
    assign incr_m         = ~^mode_r;
    assign tx_last        = o_valid_r & (beat_idx == len_r - LEN_W'(1));
    assign tx_beat        = o_valid_r & bus.o_ready;
    assign final_pkt      = cfg_pkt_count != '0 && pkt_cnt == cfg_pkt_count - LEN_W'(1);
    assign rx_beat        = bus.i_valid & bus.i_ready;
    assign rx_exp         = pat(mode_r, rx_cnt, rx_lfsr);
    assign bus.o_valid    = o_valid_r;
    assign bus.o_last     = tx_last;
    assign bus.o_fragment = o_valid_r ? pat(mode_r, tx_cnt, tx_lfsr) : '0;
    assign bus.i_ready    = cfg_enable & (~cfg_throttle_en | ~thr_cnt[THR_W-1]);

    // Once a beat is offered it is never retracted; mid-packet the next beat
    // only needs link_up, so a dropped cfg_enable still completes the packet.
    always_ff @(posedge hs_clock or posedge pcie_reset)
        if (pcie_reset) begin
            state     <= IDLE;
            o_valid_r <= 1'b0;
            mode_r    <= 2'd0;
            len_r     <= LEN_W'(1);
            beat_idx  <= '0;
            pkt_cnt   <= '0;
        end else if (idle_clr) begin
            state <= IDLE;
        end else if (state == IDLE) begin
            if (cfg_enable && link_up) begin
                state     <= SEND;
                o_valid_r <= 1'b1;
                mode_r    <= cfg_mode;
                len_r     <= cfg_pkt_len == '0 ? LEN_W'(1) : cfg_pkt_len;
                beat_idx  <= '0;
                pkt_cnt   <= '0;
            end
        end else if (state == SEND) begin
            if (tx_beat) begin
                beat_idx <= tx_last ? '0 : beat_idx + LEN_W'(1);
                pkt_cnt  <= tx_last ? pkt_cnt + LEN_W'(1) : pkt_cnt;
                if (tx_last && final_pkt) begin
                    state     <= DONE;
                    o_valid_r <= 1'b0;
                end else if (tx_last && !cfg_enable) begin
                    state     <= IDLE;
                    o_valid_r <= 1'b0;
                end else begin
                    o_valid_r <= link_up & (cfg_enable | ~tx_last);
                end
            end else if (!o_valid_r) begin
                if (!cfg_enable && beat_idx == '0)
                    state <= IDLE;
                else
                    o_valid_r <= link_up;
            end
        end else if (!cfg_enable) begin
            state <= IDLE;
        end

    always_ff @(posedge hs_clock or posedge pcie_reset)
        if (pcie_reset) begin
            tx_cnt  <= DATA_W'(1);
            rx_cnt  <= DATA_W'(1);
            tx_lfsr <= LFSR_SEED;
            rx_lfsr <= LFSR_SEED;
        end else if (idle_clr) begin
            tx_cnt  <= DATA_W'(1);
            rx_cnt  <= DATA_W'(1);
            tx_lfsr <= LFSR_SEED;
            rx_lfsr <= LFSR_SEED;
        end else begin
            tx_cnt  <= tx_beat && incr_m ? tx_cnt + DATA_W'(1) : tx_cnt;
            tx_lfsr <= tx_beat && mode_r == 2'd2 ? lfsr_next(tx_lfsr) : tx_lfsr;
            rx_cnt  <= rx_beat && incr_m ? rx_cnt + DATA_W'(1) : rx_cnt;
            rx_lfsr <= rx_beat && mode_r == 2'd2 ? lfsr_next(rx_lfsr) : rx_lfsr;
        end

    always_ff @(posedge hs_clock or posedge pcie_reset)
        if (pcie_reset) begin
            tx_beats       <= '0;
            rx_beats       <= '0;
            err_count      <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
        end else if (idle_clr) begin
            tx_beats       <= '0;
            rx_beats       <= '0;
            err_count      <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
        end else begin
            tx_beats <= tx_beat && ~&tx_beats ? tx_beats + 32'd1 : tx_beats;
            rx_beats <= rx_beat && ~&rx_beats ? rx_beats + 32'd1 : rx_beats;
            if (rx_beat && bus.i_payload != rx_exp) begin
                err_count <= ~&err_count ? err_count + 16'd1 : err_count;
                if (err_count == '0) begin
                    first_err_data <= bus.i_payload;
                    first_err_exp  <= rx_exp;
                end
            end
        end

    // MSB of the free-running counter gives a 50% ready duty over 2^THR_W cycles.
    always_ff @(posedge hs_clock or posedge pcie_reset)
        if (pcie_reset)
            thr_cnt <= '0;
        else
            thr_cnt <= cfg_enable ? thr_cnt + THR_W'(1) : '0;
endmodule

// File: tb/tb_noc_stream_traffic_gen_chk.sv
// tb_noc_stream_traffic_gen_chk: directed scenario bench for the NoC stream traffic gen/checker
module tb_noc_stream_traffic_gen_chk;
    logic        hs_clock = 1'b0;
    logic        pcie_reset = 1'b1;
    logic        cfg_enable = 1'b0;
    logic        cfg_clear = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [15:0] cfg_pkt_len = 16'd0;
    logic [15:0] cfg_pkt_count = 16'd0;
    logic        cfg_throttle_en = 1'b0;
    logic        link_up = 1'b0;
    logic        o_ready_tb = 1'b0;
    logic        i_valid_tb = 1'b0;
    logic [31:0] i_payload_tb = 32'd0;
    logic        loop = 1'b0;
    logic        corrupt = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] tx_beats;
    logic [31:0] rx_beats;
    logic [15:0] err_count;
    logic [31:0] first_err_data;
    logic [31:0] first_err_exp;
    logic [31:0] got_d [0:15];
    logic        got_l [0:15];
    int          tests = 0;
    int          fails = 0;

    noc_stream_traffic_gen_chk_if #(.DATA_W(32)) bus ();

    assign bus.o_ready   = loop ? bus.i_ready : o_ready_tb;
    assign bus.i_valid   = loop ? bus.o_valid : i_valid_tb;
    assign bus.i_payload = loop ? (corrupt ? 32'hDEAD : bus.o_fragment) : i_payload_tb;

    noc_stream_traffic_gen_chk dut (
        .hs_clock        (hs_clock),
        .pcie_reset      (pcie_reset),
        .cfg_enable      (cfg_enable),
        .cfg_clear       (cfg_clear),
        .cfg_mode        (cfg_mode),
        .cfg_pkt_len     (cfg_pkt_len),
        .cfg_pkt_count   (cfg_pkt_count),
        .cfg_throttle_en (cfg_throttle_en),
        .link_up         (link_up),
        .bus             (bus),
        .busy            (busy),
        .done            (done),
        .tx_beats        (tx_beats),
        .rx_beats        (rx_beats),
        .err_count       (err_count),
        .first_err_data  (first_err_data),
        .first_err_exp   (first_err_exp)
    );

    always #5 hs_clock = ~hs_clock;

    task automatic tick;
        @(posedge hs_clock);
        #1;
    endtask

    task automatic clear_and_idle;
        cfg_enable = 1'b0;
        loop = 1'b0;
        o_ready_tb = 1'b1;
        for (int c = 0; c < 100 && busy; c++) tick();
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        tests++;
        if ({bus.o_valid, bus.o_last, bus.i_ready, busy, done} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags got %b want 00000", {bus.o_valid, bus.o_last, bus.i_ready, busy, done});
        end
        tests++;
        if ({tx_beats, rx_beats, err_count, first_err_data, first_err_exp, bus.o_fragment} !== '0) begin
            fails++;
            $display("FAIL reset_counts got tx=%0d rx=%0d err=%0d want all 0", tx_beats, rx_beats, err_count);
        end
        pcie_reset = 1'b0;
        tick();
    endtask

    task automatic test_incr_packets;
        int n = 0;
        cfg_mode = 2'd0;
        cfg_pkt_len = 16'd4;
        cfg_pkt_count = 16'd3;
        o_ready_tb = 1'b1;
        link_up = 1'b1;
        cfg_enable = 1'b1;
        for (int c = 0; c < 60 && n < 12; c++) begin
            if (bus.o_valid && bus.o_ready) begin
                got_d[n] = bus.o_fragment;
                got_l[n] = bus.o_last;
                n++;
            end
            tick();
        end
        tests++;
        if (n != 12) begin
            fails++;
            $display("FAIL incr_beat_count got %0d want 12", n);
        end
        for (int i = 0; i < 12; i++) begin
            tests++;
            if (got_d[i] !== 32'(i + 1) || got_l[i] !== (i % 4 == 3)) begin
                fails++;
                $display("FAIL incr_beat%0d got data=%0h last=%b want data=%0h last=%b",
                         i, got_d[i], got_l[i], i + 1, i % 4 == 3);
            end
        end
        tests++;
        if ({done, busy, bus.o_valid} !== 3'b100 || tx_beats !== 32'd12) begin
            fails++;
            $display("FAIL incr_done got done=%b busy=%b valid=%b tx=%0d want 1 0 0 12",
                     done, busy, bus.o_valid, tx_beats);
        end
        cfg_enable = 1'b0;
        tick();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL incr_done_clear got %b want 0", done);
        end
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        tests++;
        if (tx_beats !== 32'd0) begin
            fails++;
            $display("FAIL clear_tx_beats got %0d want 0", tx_beats);
        end
    endtask

    task automatic test_lfsr_throttle_loopback;
        int n = 0;
        logic [31:0] lfsr_exp [0:4];
        lfsr_exp[0] = 32'd1;
        lfsr_exp[1] = 32'd3;
        lfsr_exp[2] = 32'd6;
        lfsr_exp[3] = 32'd13;
        lfsr_exp[4] = 32'd27;
        cfg_mode = 2'd2;
        cfg_pkt_len = 16'd5;
        cfg_pkt_count = 16'd0;
        cfg_throttle_en = 1'b1;
        loop = 1'b1;
        cfg_enable = 1'b1;
        #1;
        for (int k = 0; k < 600; k++) begin
            if (k == 0 || k == 127 || k == 128 || k == 255 || k == 256 || k == 384) begin
                tests++;
                if (bus.i_ready !== ((k % 256) < 128)) begin
                    fails++;
                    $display("FAIL throttle_k%0d got %b want %b", k, bus.i_ready, (k % 256) < 128);
                end
            end
            if (bus.o_valid && bus.i_ready) begin
                if (n < 5) got_d[n] = bus.o_fragment;
                n++;
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (got_d[i] !== lfsr_exp[i]) begin
                fails++;
                $display("FAIL lfsr_word%0d got %0h want %0h", i, got_d[i], lfsr_exp[i]);
            end
        end
        tests++;
        if (tx_beats !== 32'(n) || rx_beats !== 32'(n) || err_count !== 16'd0) begin
            fails++;
            $display("FAIL loop_counts got tx=%0d rx=%0d err=%0d want tx=rx=%0d err=0",
                     tx_beats, rx_beats, err_count, n);
        end
        cfg_throttle_en = 1'b0;
        clear_and_idle();
    endtask

    task automatic test_mismatch;
        int n = 0;
        cfg_mode = 2'd0;
        cfg_pkt_len = 16'd4;
        cfg_pkt_count = 16'd0;
        loop = 1'b1;
        cfg_enable = 1'b1;
        #1;
        for (int c = 0; c < 100 && n < 10; c++) begin
            corrupt = n == 4;
            if (bus.o_valid && bus.i_ready) n++;
            tick();
        end
        corrupt = 1'b0;
        tests++;
        if (rx_beats !== 32'd10 || err_count !== 16'd1) begin
            fails++;
            $display("FAIL mismatch_count got rx=%0d err=%0d want 10 1", rx_beats, err_count);
        end
        tests++;
        if (first_err_data !== 32'hDEAD || first_err_exp !== 32'd5) begin
            fails++;
            $display("FAIL mismatch_capture got data=%0h exp=%0h want dead 5", first_err_data, first_err_exp);
        end
        clear_and_idle();
    endtask

    task automatic test_hold_mid_beat;
        cfg_mode = 2'd0;
        cfg_pkt_len = 16'd16;
        cfg_pkt_count = 16'd0;
        o_ready_tb = 1'b1;
        link_up = 1'b1;
        cfg_enable = 1'b1;
        for (int c = 0; c < 50 && !(bus.o_valid && bus.o_fragment == 32'd7); c++) tick();
        o_ready_tb = 1'b0;
        link_up = 1'b0;
        repeat (4) tick();
        tests++;
        if (bus.o_valid !== 1'b1 || bus.o_fragment !== 32'd7 || tx_beats !== 32'd6) begin
            fails++;
            $display("FAIL hold_beat7 got valid=%b data=%0h tx=%0d want 1 7 6",
                     bus.o_valid, bus.o_fragment, tx_beats);
        end
        o_ready_tb = 1'b1;
        link_up = 1'b1;
        tick();
        tests++;
        if (bus.o_valid !== 1'b1 || bus.o_fragment !== 32'd8 || tx_beats !== 32'd7) begin
            fails++;
            $display("FAIL resume_beat8 got valid=%b data=%0h tx=%0d want 1 8 7",
                     bus.o_valid, bus.o_fragment, tx_beats);
        end
        cfg_enable = 1'b0;
        for (int c = 0; c < 50 && busy; c++) tick();
        tests++;
        if (busy !== 1'b0 || bus.o_valid !== 1'b0 || tx_beats !== 32'd16) begin
            fails++;
            $display("FAIL hold_drain got busy=%b valid=%b tx=%0d want 0 0 16", busy, bus.o_valid, tx_beats);
        end
        clear_and_idle();
    endtask

    task automatic test_enable_drop;
        int n = 0;
        cfg_mode = 2'd0;
        cfg_pkt_len = 16'd8;
        cfg_pkt_count = 16'd0;
        o_ready_tb = 1'b1;
        link_up = 1'b1;
        cfg_enable = 1'b1;
        for (int c = 0; c < 50 && !(bus.o_valid && bus.o_fragment == 32'd2); c++) tick();
        cfg_enable = 1'b0;
        for (int c = 0; c < 40 && (busy || n == 0); c++) begin
            if (bus.o_valid && bus.o_ready && n < 16) begin
                got_d[n] = bus.o_fragment;
                got_l[n] = bus.o_last;
                n++;
            end
            tick();
        end
        tests++;
        if (n != 7) begin
            fails++;
            $display("FAIL drop_beat_count got %0d want 7", n);
        end
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (got_d[i] !== 32'(i + 2) || got_l[i] !== (i == 6)) begin
                fails++;
                $display("FAIL drop_beat%0d got data=%0h last=%b want data=%0h last=%b",
                         i, got_d[i], got_l[i], i + 2, i == 6);
            end
        end
        tick();
        tests++;
        if (bus.o_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL drop_idle got valid=%b busy=%b want 0 0", bus.o_valid, busy);
        end
        clear_and_idle();
    endtask

    task automatic test_reset_mid_send;
        cfg_mode = 2'd0;
        cfg_pkt_len = 16'd4;
        cfg_pkt_count = 16'd0;
        o_ready_tb = 1'b1;
        link_up = 1'b1;
        cfg_enable = 1'b1;
        repeat (6) tick();
        tests++;
        if (busy !== 1'b1 || tx_beats !== 32'd5) begin
            fails++;
            $display("FAIL pre_reset got busy=%b tx=%0d want 1 5", busy, tx_beats);
        end
        #3;
        pcie_reset = 1'b1;
        #1;
        tests++;
        if (bus.o_valid !== 1'b0 || busy !== 1'b0 || tx_beats !== 32'd0) begin
            fails++;
            $display("FAIL async_reset got valid=%b busy=%b tx=%0d want 0 0 0", bus.o_valid, busy, tx_beats);
        end
        #2;
        pcie_reset = 1'b0;
        tick();
        tests++;
        if (bus.o_valid !== 1'b1 || bus.o_fragment !== 32'd1) begin
            fails++;
            $display("FAIL restart got valid=%b data=%0h want 1 1", bus.o_valid, bus.o_fragment);
        end
        cfg_enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_incr_packets();
        test_lfsr_throttle_loopback();
        test_mismatch();
        test_hold_mid_beat();
        test_enable_drop();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
